booth_r4_seq_multiplier: RTL and testbench

- Parametrised successor to the team's 32-bit sequential multiplier.
- Computes an N x N product using radix-4 Booth recoding, retiring 2 multiplier bits per cycle.
- Runtime-selectable signed or unsigned mode; start/busy/done handshake.
- Sits in the datapath as a shared multi-cycle multiply unit behind the ALU issue logic.

---
 rtl/seq_mul_pkg.sv | 28 ++
 rtl/booth_r4_pp_gen.sv | 29 ++
 rtl/booth_r4_seq_multiplier.sv | 140 ++++++++++++++
 tb/tb_booth_r4_seq_multiplier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// the recoded Booth digit and its decoder.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One radix-4 digit in sign/magnitude form: value = (neg ? -1 : 1) * (two ? 2 : 1),
  // or 0 when zero is set.
  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;

  // bits = {b1, b0, guard}
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t d;
    d.zero = (bits == 3'b000) || (bits == 3'b111);
    d.two  = (bits == 3'b100) || (bits == 3'b011);
    d.neg  = bits[2] && !d.zero;
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial-product generator: digit x multiplicand as a
// (W+2)-bit two's-complement value.
module booth_r4_pp_gen
  import seq_mul_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [2:0]   digit,
  input  logic [W-1:0] mcand,
  output logic [W+1:0] pp
);

  booth_digit_t d;
  logic [W+1:0] ext;
  logic [W+1:0] mag;

  assign d   = booth_digit_t'(digit);
  // Two extra sign bits so that 2 x mcand and its negation never overflow.
  assign ext = {{2{mcand[W-1]}}, mcand};
  assign mag = d.two ? {ext[W:0], 1'b0} : ext;

  always_comb begin
    pp = '0;
    if (!d.zero) begin
      pp = d.neg ? (~mag + 1'b1) : mag;
    end
  end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Sequential N x N radix-4 Booth multiplier, signed/unsigned at runtime, two
// multiplier bits retired per enabled cycle. BOOTH_R4_EARLY_TERM_EN adds early exit.
module booth_r4_seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W    = N + 2;
  localparam int ITER = W / 2;
  localparam int CW   = $clog2(ITER + 1);

  state_t         state;
  state_t         state_next;
  logic [W+1:0]   acc;
  logic [W-1:0]   mplr;
  logic           guard;
  logic [W-1:0]   mcand;
  logic [CW-1:0]  cnt;

  logic [2:0]     digit;
  logic [W+1:0]   pp;
  logic [W+1:0]   sum;
  logic [W+1:0]   next_acc;
  logic [W-1:0]   next_mplr;
  logic           next_guard;
  logic [CW-1:0]  cnt_inc;
  logic           last_digit;
  logic           finish;
  logic           capture;
  logic [2*N-1:0] product_next;

  assign digit = booth_decode({mplr[1:0], guard});

  booth_r4_pp_gen #(.W(W)) u_pp_gen (
    .digit (digit),
    .mcand (mcand),
    .pp    (pp)
  );

  // {acc, mplr} is shifted as one arithmetic register; acc absorbs the sign.
  assign sum        = acc + pp;
  assign next_acc   = {{2{sum[W+1]}}, sum[W+1:2]};
  assign next_mplr  = {sum[1:0], mplr[W-1:2]};
  assign next_guard = mplr[1];
  assign cnt_inc    = cnt + 1'b1;
  assign last_digit = (cnt == CW'(ITER - 1));

`ifdef BOOTH_R4_EARLY_TERM_EN
  localparam int SW = $clog2(W + 1);

  logic [SW-1:0]      rem_shift;
  logic [SW-1:0]      done_shift;
  logic [W-1:0]       rem_mask;
  logic               rem_zero;
  logic               rem_ones;
  logic signed [2*W+1:0] full_s;
  logic signed [2*W+1:0] aligned;

  // Low bits of next_mplr still hold unconsumed multiplier bits; when they and
  // the guard agree, every remaining digit is zero and only shifts are left.
  assign rem_shift  = SW'(cnt_inc) << 1;
  assign done_shift = SW'(W) - rem_shift;
  assign rem_mask   = {W{1'b1}} >> rem_shift;
  assign rem_zero   = ((next_mplr & rem_mask) == '0) && !next_guard;
  assign rem_ones   = ((next_mplr | ~rem_mask) == '1) && next_guard;
  assign finish     = last_digit || rem_zero || rem_ones;

  assign full_s       = {next_acc, next_mplr};
  assign aligned      = full_s >>> done_shift;
  assign product_next = aligned[2*N-1:0];
`else
  assign finish       = last_digit;
  assign product_next = {next_acc[N-3:0], next_mplr};
`endif

  assign capture = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)  state_next = ST_RUN;
      ST_RUN:  if (finish) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mplr    <= '0;
      guard   <= 1'b0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (en) begin
      if (capture) begin
        mcand <= {{2{signed_mode & multiplicand[N-1]}}, multiplicand};
        mplr  <= {{2{signed_mode & multiplier[N-1]}}, multiplier};
        guard <= 1'b0;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        acc   <= next_acc;
        mplr  <= next_mplr;
        guard <= next_guard;
        cnt   <= cnt_inc;
        if (finish) begin
          product <= product_next;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Directed self-checking bench for booth_r4_seq_multiplier (N=32): products,
// latency, handshake, reset abort, clock-enable stall.
module tb_booth_r4_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int errors = 0;
  int checks = 0;

  booth_r4_seq_multiplier #(.N(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic launch(input logic sm, input logic [31:0] a, input logic [31:0] b);
    start        = 1'b1;
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles (starting at 1) until done; optionally drops en for a window.
  task automatic wait_done(input string tag, input int stall_at, input int stall_len,
                           output int cyc, output int busy_cyc);
    cyc = 1;
    busy_cyc = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cyc++;
      en = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      cyc++;
    end
    en = 1'b1;
    check({tag, " done_seen"}, 64'(done), 64'd1);
  endtask

  typedef struct {
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6] = '{
    '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 64'h0000_0000_0000_0004},
    '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000},
    '{1'b1, 32'hFFFF_FFED, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFC7},
    '{1'b1, 32'h0000_0000, 32'hFFFF_FFC4, 64'h0000_0000_0000_0000},
    '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001},
    '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001}
  };

`ifdef BOOTH_R4_EARLY_TERM_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 15;
`endif

  int cyc;
  int bcyc;

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);

    // Signed 7 x 2: latency and pulse width
    launch(1'b1, 32'd7, 32'd2);
    wait_done("7x2", 0, 0, cyc, bcyc);
    check("7x2 product", product, 64'd14);
`ifdef BOOTH_R4_EARLY_TERM_EN
    check("7x2 latency", 64'(cyc), 64'd3);
`else
    check("7x2 latency", 64'(cyc), 64'd18);
    check("7x2 busy cycles", 64'(bcyc), 64'd17);
`endif
    @(negedge clk);
    check("7x2 done width", 64'(done), 64'd0);
    check("7x2 back to idle busy", 64'(busy), 64'd0);

    // Signed corners and mode select
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].sm, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), 0, 0, cyc, bcyc);
      check($sformatf("vec%0d product", i), product, vecs[i].exp);
      @(negedge clk);
    end

    // Start held through RUN with operands changed: must not recapture
    start        = 1'b1;
    signed_mode  = 1'b1;
    multiplicand = 32'hFFFF_FFF9;
    multiplier   = 32'd3;
    @(negedge clk);
    multiplicand = 32'd5;
    multiplier   = 32'd5;
    for (int c = 1; c <= HOLD; c++) @(negedge clk);
    start = 1'b0;
    wait_done("held", 0, 0, cyc, bcyc);
    check("held product", product, 64'hFFFF_FFFF_FFFF_FFEB);

    // Start accepted in the DONE cycle
    launch(1'b1, 32'd20, 32'hFFFF_FFF6);
    check("b2b no idle busy", 64'(busy), 64'd1);
    check("b2b product held in RUN", product, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("b2b", 0, 0, cyc, bcyc);
    check("b2b product", product, 64'hFFFF_FFFF_FFFF_FF38);
`ifndef BOOTH_R4_EARLY_TERM_EN
    check("b2b latency", 64'(cyc), 64'd18);
`endif
    @(negedge clk);

    // Reset in RUN cycle 5
    launch(1'b1, 32'h1234_5678, 32'h5555_5555);
    repeat (4) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", product, 64'd0);
    launch(1'b1, 32'd2, 32'hFFFF_FF83);
    wait_done("after reset", 0, 0, cyc, bcyc);
    check("after reset product", product, 64'hFFFF_FFFF_FFFF_FF06);
    @(negedge clk);

    // en low for 4 cycles mid-RUN, then a frozen done pulse
    launch(1'b1, 32'd7, 32'd2);
    wait_done("stall", 5, 4, cyc, bcyc);
    check("stall product", product, 64'd14);
`ifndef BOOTH_R4_EARLY_TERM_EN
    check("stall latency", 64'(cyc), 64'd22);
`endif
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("done frozen", 64'(done), 64'd1);
    en = 1'b1;
    @(negedge clk);
    check("done released", 64'(done), 64'd0);

    // Unsigned 7 x 3 (early-exit case when enabled)
    launch(1'b0, 32'd7, 32'd3);
    wait_done("7x3", 0, 0, cyc, bcyc);
    check("7x3 product", product, 64'd21);
`ifdef BOOTH_R4_EARLY_TERM_EN
    check("7x3 latency", 64'(cyc), 64'd3);
`else
    check("7x3 latency", 64'(cyc), 64'd18);
`endif
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
